multi_timer: RTL and testbench
==============================

// Module: multi_timer
// PURPOSE
//  NUM_CH independent up-counting timers behind one slave bus port (cs_/as_/rw/addr/wr_data/rd_data/rdy_).
//  Each channel: one-shot or periodic mode, expire compare, sticky status flag, per-channel irq mask.
//  Successor to the single-channel timer. Adds channel count, counter width, irq masking and an optional prescaler.
//  Sits on the peripheral bus. Drives irq_vec and an ORed irq to the interrupt controller.
// PARAMETERS
//  NUM_CH  4   number of channels, 1..4
//  CNT_W   32  counter/expire width, 1..32; reads zero-extended to 32 bits
// PORTS
//  clk      in   1       system clock; all logic on posedge
//  reset    in   1       synchronous, active-high reset
//  cs_      in   1       chip select, active low
//  as_      in   1       address strobe, active low
//  rw       in   1       1=read, 0=write
//  addr     in   4       {ch[1:0], reg[1:0]}; reg 0=CTRL 1=STAT 2=EXPR 3=COUNTER
//  wr_data  in   32      write data
//  rd_data  out  32      read data, registered
//  rdy_     out  1       ready, active low, registered
//  irq_vec  out  NUM_CH  per-channel masked irq (stat & irq_en)
//  irq      out  1       OR of irq_vec
// BEHAVIOUR
//  Reset (reset=1 at posedge) clears every register:
//   rd_data=0, rdy_=1, irq_vec=0, irq=0; per channel start=0, mode=0, irq_en=0, stat=0, expr=0, counter=0.
//  Access: acc = !cs_ & !as_. rdy_ <= !acc, so rdy_ goes low 1 cycle after each accessed cycle. No wait states.
//  Read: rd_data <= selected reg when acc & rw; else rd_data <= 0.
//  Write: applied on the acc & !rw cycle.
//  Channel index >= NUM_CH: reads return 0, writes are ignored, rdy_ behaves normally.
//  CTRL layout: bit0 start, bit1 mode (0 one-shot, 1 periodic), bit2 irq_en, [15:8] presc (macro only); other bits read 0.
//  STAT layout: bit0 = sticky expire flag. A write loads wr_data[0] into it.
//  tick: 1 every clock without the macro.
//  expire[ch] = start & tick & (counter == expr).
//  Counter priority, highest first:
//   1. COUNTER write loads wr_data[CNT_W-1:0].
//   2. expire sets counter to 0.
//   3. start & tick increments counter, mod 2^CNT_W.
//  Period = (expr+1) ticks. expr=0 expires every tick.
//  Counter written above expr counts through wrap to 0, then up to expr.
//  start: a CTRL write wins. Otherwise expire in one-shot mode clears start; counter holds 0 after that.
//  stat: expire sets it and wins over a same-cycle STAT write of 0. Otherwise a STAT write loads it.
//  irq_vec[ch] registered: <= stat_next & irq_en_next, so irq follows expire by 1 cycle.
//  Setting irq_en while stat=1 raises irq next cycle. irq_en does not affect stat.
//  Channels are fully independent. Simultaneous expires on several channels all set their own stat.
//  Reset mid-count aborts everything and restores all reset values the next cycle.
// CONFIGURATION
//  TIMER_PRESCALER_EN defined:
//   - Per-channel 8-bit presc field in CTRL[15:8] plus an internal 8-bit prescale counter pc.
//   - tick = start & (pc == presc). On tick pc <= 0, else pc <= pc+1 while start.
//   - pc <= 0 when start=0 or on a COUNTER write.
//   - Period = (expr+1)*(presc+1) clocks. presc=0 behaves exactly as the macro-undefined build.
//  TIMER_PRESCALER_EN undefined:
//   - No prescaler logic. CTRL[15:8] reads 0 and ignores writes. tick=1.
// TESTING
//  T1 reset: hold reset 2 cycles mid-count -> all registers 0, rdy_=1, irq=0, rd_data=0.
//  T2 one-shot: ch0 EXPR=5, CTRL=0x5 -> stat/irq_vec[0] 1 cycle after expire, start reads 0, counter stays 0.
//  T3 periodic: ch2 EXPR=3, CTRL=0x7 -> expire every 4 clocks. STAT write 0 clears irq. Expire on the same cycle keeps stat=1.
//  T4 bus: read each reg of ch1 -> data next cycle with rdy_=0. Idle cycle -> rd_data=0. Access to ch index >= NUM_CH -> reads 0, no state change.
//  T5 priority: COUNTER write 0xFFFF_FFF0 with EXPR=2 -> no expire until wrap; counter write on an expire cycle wins.
//  T6 prescaler (macro on): presc=3, EXPR=1, periodic -> expire every 8 clocks. Macro off: CTRL[15:8] reads 0.

Source files
------------

// File: rtl/multi_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : multi_timer                                                 |
// | Description: NUM_CH up-counting timers (one-shot/periodic) behind a      |
// |              cs_/as_ slave port; optional prescaler TIMER_PRESCALER_EN.  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [3:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam logic [1:0] c_REG_CTRL = 2'd0;
  localparam logic [1:0] c_REG_STAT = 2'd1;
  localparam logic [1:0] c_REG_EXPR = 2'd2;
  localparam logic [1:0] c_REG_CNT  = 2'd3;

  logic              w_acc;
  logic [1:0]        w_ch;
  logic [1:0]        w_reg;
  logic [3:0][31:0]  w_rd_ch;
  logic [NUM_CH-1:0] w_irq_next;
  logic [31:0]       r_rd_data;
  logic              r_rdy_n;
  logic [NUM_CH-1:0] r_irq_vec;
  logic              w_unused_bits;

  assign w_acc         = !cs_ && !as_;
  assign w_ch          = addr[3:2];
  assign w_reg         = addr[1:0];
  assign w_unused_bits = ^wr_data;

  // Four address slots always exist; slots beyond NUM_CH read as zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    if (gi < NUM_CH) begin : g_active
      logic             r_start, r_mode, r_irq_en, r_stat;
      logic [CNT_W-1:0] r_expr, r_counter;
      logic             w_wr, w_wr_ctrl, w_wr_stat, w_wr_expr, w_wr_cnt;
      logic             w_tick, w_expire;
      logic             w_start_next, w_stat_next, w_irq_en_next;
      logic [CNT_W-1:0] w_counter_next;
      logic [7:0]       w_presc_rd;

      assign w_wr      = w_acc && !rw && (w_ch == 2'(gi));
      assign w_wr_ctrl = w_wr && (w_reg == c_REG_CTRL);
      assign w_wr_stat = w_wr && (w_reg == c_REG_STAT);
      assign w_wr_expr = w_wr && (w_reg == c_REG_EXPR);
      assign w_wr_cnt  = w_wr && (w_reg == c_REG_CNT);

`ifdef TIMER_PRESCALER_EN
      logic [7:0] r_presc, r_pc;

      assign w_tick     = r_start && (r_pc == r_presc);
      assign w_presc_rd = r_presc;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_presc <= 8'd0;
          r_pc    <= 8'd0;
        end else begin
          if (w_wr_ctrl) r_presc <= wr_data[15:8];
          if (!r_start || w_wr_cnt || w_tick) r_pc <= 8'd0;
          else                                r_pc <= r_pc + 8'd1;
        end
      end
`else
      assign w_tick     = 1'b1;
      assign w_presc_rd = 8'd0;
`endif

      assign w_expire = r_start && w_tick && (r_counter == r_expr);

      always_comb begin
        w_counter_next = r_counter;
        w_start_next   = r_start;
        w_stat_next    = r_stat;
        w_irq_en_next  = r_irq_en;
        if (w_wr_cnt)                 w_counter_next = wr_data[CNT_W-1:0];
        else if (w_expire)            w_counter_next = '0;
        else if (r_start && w_tick)   w_counter_next = r_counter + CNT_W'(1);
        if (w_wr_ctrl)                w_start_next   = wr_data[0];
        else if (w_expire && !r_mode) w_start_next   = 1'b0;
        // Expire beats a simultaneous software clear so no event is lost.
        if (w_expire)                 w_stat_next    = 1'b1;
        else if (w_wr_stat)           w_stat_next    = wr_data[0];
        if (w_wr_ctrl)                w_irq_en_next  = wr_data[2];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_start   <= 1'b0;
          r_mode    <= 1'b0;
          r_irq_en  <= 1'b0;
          r_stat    <= 1'b0;
          r_expr    <= '0;
          r_counter <= '0;
        end else begin
          r_start   <= w_start_next;
          r_irq_en  <= w_irq_en_next;
          r_stat    <= w_stat_next;
          r_counter <= w_counter_next;
          if (w_wr_ctrl) r_mode <= wr_data[1];
          if (w_wr_expr) r_expr <= wr_data[CNT_W-1:0];
        end
      end

      assign w_irq_next[gi] = w_stat_next && w_irq_en_next;
      assign w_rd_ch[gi] =
          (w_reg == c_REG_CTRL) ? {16'd0, w_presc_rd, 5'd0, r_irq_en, r_mode, r_start} :
          (w_reg == c_REG_STAT) ? {31'd0, r_stat} :
          (w_reg == c_REG_EXPR) ? 32'(r_expr) : 32'(r_counter);
    end else begin : g_absent
      assign w_rd_ch[gi] = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= 32'd0;
      r_rdy_n   <= 1'b1;
      r_irq_vec <= '0;
    end else begin
      r_rdy_n   <= !w_acc;
      r_rd_data <= (w_acc && rw) ? w_rd_ch[w_ch] : 32'd0;
      r_irq_vec <= w_irq_next;
    end
  end

  assign rd_data = r_rd_data;
  assign rdy_    = r_rdy_n;
  assign irq_vec = r_irq_vec;
  assign irq     = |r_irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_multi_timer                                              |
// | Description: Vector table, directed sequences and random traffic against |
// |              a behavioural timer model (3 channels, 4th slot unmapped).  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_multi_timer;
  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cs_ = 1'b1;
  logic           as_ = 1'b1;
  logic           rw = 1'b1;
  logic [3:0]     addr = 4'd0;
  logic [31:0]    wr_data = 32'd0;
  logic [31:0]    rd_data;
  logic           rdy_;
  logic [NCH-1:0] irq_vec;
  logic           irq;

  int checks = 0;
  int errors = 0;

  multi_timer #(.NUM_CH(NCH), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_vec(irq_vec), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents per channel, updated once per clock.
  bit [31:0]    m_expr [NCH];
  bit [31:0]    m_cnt  [NCH];
  bit [7:0]     m_presc[NCH];
  bit [7:0]     m_pc   [NCH];
  bit           m_start[NCH], m_mode[NCH], m_ien[NCH], m_stat[NCH];
  bit [31:0]    m_rd;
  bit           m_rdy;
  bit [NCH-1:0] m_irqv;

  function automatic void model_step(bit r, bit c, bit a, bit w_rw, bit [3:0] ad, bit [31:0] wd);
    int ch;
    int rg;
    bit acc;
    ch  = int'(ad[3:2]);
    rg  = int'(ad[1:0]);
    acc = !c && !a;
    if (r) begin
      for (int k = 0; k < NCH; k++) begin
        m_expr[k] = 0; m_cnt[k] = 0; m_presc[k] = 0; m_pc[k] = 0;
        m_start[k] = 0; m_mode[k] = 0; m_ien[k] = 0; m_stat[k] = 0;
      end
      m_rd = 0; m_rdy = 1; m_irqv = '0;
      return;
    end
    m_rd = 0;
    if (acc && w_rw && ch < NCH) begin
      case (rg)
        0: m_rd = {16'd0, m_presc[ch], 5'd0, m_ien[ch], m_mode[ch], m_start[ch]};
        1: m_rd = {31'd0, m_stat[ch]};
        2: m_rd = m_expr[ch];
        default: m_rd = m_cnt[ch];
      endcase
    end
    m_rdy = !acc;
    for (int k = 0; k < NCH; k++) begin
      bit wr;
      bit tick;
      bit fire;
      wr = acc && !w_rw && (ch == k);
`ifdef TIMER_PRESCALER_EN
      tick = m_start[k] && (m_pc[k] == m_presc[k]);
      if (!m_start[k] || (wr && rg == 3) || tick) m_pc[k] = 0;
      else                                        m_pc[k] = m_pc[k] + 1;
`else
      tick = 1;
`endif
      fire = m_start[k] && tick && (m_cnt[k] == m_expr[k]);
      if (wr && rg == 3)           m_cnt[k] = wd;
      else if (fire)               m_cnt[k] = 0;
      else if (m_start[k] && tick) m_cnt[k] = m_cnt[k] + 1;
      if (wr && rg == 0) begin
        m_start[k] = wd[0]; m_mode[k] = wd[1]; m_ien[k] = wd[2];
`ifdef TIMER_PRESCALER_EN
        m_presc[k] = wd[15:8];
`endif
      end else if (fire && !m_mode[k]) begin
        m_start[k] = 0;
      end
      if (fire)                m_stat[k] = 1;
      else if (wr && rg == 1)  m_stat[k] = wd[0];
      if (wr && rg == 2)       m_expr[k] = wd;
      m_irqv[k] = m_stat[k] && m_ien[k];
    end
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  task automatic cyc(bit r, bit c, bit a, bit w_rw, bit [3:0] ad, bit [31:0] wd);
    reset = r; cs_ = c; as_ = a; rw = w_rw; addr = ad; wr_data = wd;
    model_step(r, c, a, w_rw, ad, wd);
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, m_rd);
    chk("rdy_", 32'(rdy_), 32'(m_rdy));
    chk("irq_vec", 32'(irq_vec), 32'(m_irqv));
    chk("irq", 32'(irq), 32'(|m_irqv));
  endtask

  task automatic wr(bit [3:0] ad, bit [31:0] wd); cyc(0, 0, 0, 0, ad, wd); endtask
  task automatic rd(bit [3:0] ad);                cyc(0, 0, 0, 1, ad, 32'd0); endtask
  task automatic idle();                          cyc(0, 1, 1, 1, 4'd0, 32'd0); endtask

  // Clears STAT right after each observed irq; distance between rises is the period.
  task automatic measure(int ch, int exp_per, int n);
    int  last;
    int  got;
    bit  hit;
    last = -1;
    got  = 0;
    for (int k = 0; k < n; k++) begin
      if (irq_vec[ch]) wr(4'(ch * 4 + 1), 32'd0);
      else             idle();
      hit = irq_vec[ch];
      if (hit) begin
        if (last >= 0) begin
          chk("period", 32'(k - last), 32'(exp_per));
          got++;
        end
        last = k;
      end
    end
    chk("period_seen", 32'(got >= 2), 32'd1);
  endtask

  typedef struct {
    bit        cs_n;
    bit        as_n;
    bit        rw;
    bit [3:0]  addr;
    bit [31:0] wd;
    bit [31:0] e_rd;
    bit        e_rdy;
    bit        e_irq;
  } vec_t;

  vec_t tbl[19];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  k;
    bit  found;
    bit  r;
    bit  c;
    bit  a;
    bit  w_rw;
    bit [3:0]  ad;
    bit [31:0] wd;

    tbl[0]  = '{0, 0, 0, 4'd6,  32'd100,        32'd0,      0, 0};
    tbl[1]  = '{0, 0, 1, 4'd6,  32'd0,          32'd100,    0, 0};
    tbl[2]  = '{1, 1, 1, 4'd6,  32'd0,          32'd0,      1, 0};
    tbl[3]  = '{0, 1, 1, 4'd6,  32'd0,          32'd0,      1, 0};
    tbl[4]  = '{1, 0, 1, 4'd6,  32'd0,          32'd0,      1, 0};
    tbl[5]  = '{0, 0, 0, 4'd4,  32'hFFFF_00F6,  32'd0,      0, 0};
    tbl[6]  = '{0, 0, 1, 4'd4,  32'd0,          32'd6,      0, 0};
    tbl[7]  = '{0, 0, 0, 4'd7,  32'h1234,       32'd0,      0, 0};
    tbl[8]  = '{0, 0, 1, 4'd7,  32'd0,          32'h1234,   0, 0};
    tbl[9]  = '{0, 0, 1, 4'd5,  32'd0,          32'd0,      0, 0};
    tbl[10] = '{0, 0, 0, 4'd5,  32'hFFFF_FFFF,  32'd0,      0, 1};
    tbl[11] = '{0, 0, 1, 4'd5,  32'd0,          32'd1,      0, 1};
    tbl[12] = '{0, 0, 0, 4'd5,  32'hFFFF_FFFE,  32'd0,      0, 0};
    tbl[13] = '{0, 0, 0, 4'd12, 32'd7,          32'd0,      0, 0};
    tbl[14] = '{0, 0, 1, 4'd12, 32'd0,          32'd0,      0, 0};
    tbl[15] = '{0, 0, 0, 4'd15, 32'd5,          32'd0,      0, 0};
    tbl[16] = '{0, 0, 1, 4'd15, 32'd0,          32'd0,      0, 0};
    tbl[17] = '{0, 0, 1, 4'd4,  32'd0,          32'd6,      0, 0};
    tbl[18] = '{0, 0, 1, 4'd2,  32'd0,          32'd0,      0, 0};

    // T1: reset, count, reset again mid-count
    cyc(1, 1, 1, 1, 4'd0, 32'd0);
    cyc(1, 1, 1, 1, 4'd0, 32'd0);
    wr(4'd2, 32'd1000);
    wr(4'd0, 32'd7);
    wr(4'd5, 32'd1);
    for (int i = 0; i < 5; i++) idle();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 1, 4'd3, 32'd0);
      chk("rst_rdy", 32'(rdy_), 32'd1);
      chk("rst_rd", rd_data, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_irqv", 32'(irq_vec), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("rst_reg", rd_data, 32'd0);
    end

    // T4: vector table
    for (int i = 0; i < 19; i++) begin
      cyc(0, tbl[i].cs_n, tbl[i].as_n, tbl[i].rw, tbl[i].addr, tbl[i].wd);
      chk("tbl_rd", rd_data, tbl[i].e_rd);
      chk("tbl_rdy", 32'(rdy_), 32'(tbl[i].e_rdy));
      chk("tbl_irq", 32'(irq), 32'(tbl[i].e_irq));
    end

    // T2: one-shot on ch0, expire 6 edges after the start write
    wr(4'd2, 32'd5);
    wr(4'd0, 32'd5);
    k = 0;
    while (k < 20 && !irq_vec[0]) begin
      idle();
      k++;
    end
    chk("oneshot_lat", 32'(k), 32'd6);
    rd(4'd0);
    chk("oneshot_ctrl", rd_data, 32'd4);
    rd(4'd3);
    chk("oneshot_cnt", rd_data, 32'd0);
    for (int i = 0; i < 3; i++) idle();
    rd(4'd3);
    chk("oneshot_hold", rd_data, 32'd0);

    // T3: periodic on ch2, period 4, then clear on an expire cycle
    wr(4'd10, 32'd3);
    wr(4'd8, 32'd7);
    measure(2, 4, 20);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_start[2] && m_cnt[2] == m_expr[2]) begin
        wr(4'd9, 32'd0);
        chk("stat_win_irq", 32'(irq_vec[2]), 32'd1);
        rd(4'd9);
        chk("stat_win_rd", rd_data, 32'd1);
        found = 1;
      end else begin
        idle();
      end
    end
    chk("stat_win_found", 32'(found), 32'd1);
    wr(4'd8, 32'd0);

    // T5: wrap-around from a high counter value, then counter write beats expire
    wr(4'd6, 32'd2);
    wr(4'd4, 32'd7);
    wr(4'd5, 32'd0);
    wr(4'd7, 32'hFFFF_FFF0);
    k = 0;
    while (k < 40 && !irq_vec[1]) begin
      idle();
      k++;
    end
    chk("wrap_lat", 32'(k), 32'd19);
    wr(4'd5, 32'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_start[1] && m_cnt[1] == m_expr[1]) begin
        wr(4'd7, 32'h40);
        rd(4'd7);
        chk("cntwr_win", rd_data, 32'h40);
        rd(4'd5);
        chk("cntwr_stat", rd_data, 32'd1);
        found = 1;
      end else begin
        idle();
      end
    end
    chk("cntwr_found", 32'(found), 32'd1);
    wr(4'd4, 32'd0);

    // T6: prescaler
`ifdef TIMER_PRESCALER_EN
    wr(4'd2, 32'd1);
    wr(4'd0, 32'h0000_0307);
    rd(4'd0);
    chk("presc_ctrl", rd_data, 32'h0000_0307);
    measure(0, 8, 40);
    wr(4'd0, 32'd0);
`else
    wr(4'd0, 32'h0000_FF00);
    rd(4'd0);
    chk("presc_off", rd_data, 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      r    = ($urandom_range(0, 399) == 0);
      c    = ($urandom_range(0, 9) == 0);
      a    = ($urandom_range(0, 9) == 0);
      w_rw = $urandom_range(0, 1) == 1;
      ad   = 4'($urandom_range(0, 15));
      case (ad[1:0])
        2'd0:    wd = {16'd0, 8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)};
        2'd1:    wd = $urandom;
        2'd2:    wd = 32'($urandom_range(0, 9));
        default: wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                  : 32'($urandom_range(0, 12));
      endcase
      cyc(r, c, a, w_rw, ad, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
